// File: rtl/serial_pkg.sv
// serial_pkg: constants shared by the serial receive (serial_deser) and
// transmit-side shifter blocks.
//   DIR_MSB_FIRST / DIR_LSB_FIRST : bit-order encodings of the dir port
//   SER_WIDTH                     : default serial word width
package serial_pkg;

   localparam logic DIR_MSB_FIRST = 1'b0;
   localparam logic DIR_LSB_FIRST = 1'b1;

   localparam int SER_WIDTH = 8;

endpackage

// File: rtl/serial_deser.sv
// serial_deser: serial-to-parallel receiver with a single-entry
// valid/ready output buffer.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   en       in   bit strobe; sd sampled on edges where en=1
//   dir      in   bit order (0 MSB first, 1 LSB first), latched at frame start
//   sd       in   serial data
//   clr      in   synchronous frame abort; also clears overrun
//   q        out  received word (output buffer)
//   q_valid  out  q holds an unconsumed word
//   q_ready  in   consumer accepts q when q_valid=1
//   overrun  out  sticky: a completed word was dropped
//   bit_cnt  out  bits received in the current frame
module serial_deser
   import serial_pkg::*;
#(
   parameter  int WIDTH = SER_WIDTH,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic             sd,
   input  logic             clr,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   input  logic             q_ready,
   output logic             overrun,
   output logic [CNT_W-1:0] bit_cnt
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] sr_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             dir_l_reg;
   logic [WIDTH-1:0] q_reg;
   logic             q_valid_reg;
   logic             overrun_reg;

   logic             dir_eff;
   logic [WIDTH-1:0] shifted;
   logic             complete;
   logic             buf_free;

   always_comb begin
      // The first bit of a frame must follow the live dir input, since
      // dir_l only captures it on this same edge.
      dir_eff  = (cnt_reg == '0) ? dir : dir_l_reg;
      shifted  = sr_reg;
      if (dir_eff == DIR_LSB_FIRST) begin
         shifted = {sd, sr_reg[WIDTH-1:1]};
      end else begin
         shifted = {sr_reg[WIDTH-2:0], sd};
      end
      complete = en && !clr && (cnt_reg == CNT_LAST);
      // A word being consumed on this edge frees the slot for a new one.
      buf_free = !q_valid_reg || q_ready;
   end

   // Shift register, bit counter and latched order.
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_reg    <= '0;
         cnt_reg   <= '0;
         dir_l_reg <= DIR_MSB_FIRST;
      end else if (clr) begin
         sr_reg  <= '0;
         cnt_reg <= '0;
      end else if (en) begin
         if (cnt_reg == '0) begin
            dir_l_reg <= dir;
         end
         if (cnt_reg == CNT_LAST) begin
            sr_reg  <= '0;
            cnt_reg <= '0;
         end else begin
            sr_reg  <= shifted;
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   // Single-entry output buffer and sticky overrun flag. A consume is
   // honoured even on a clr edge so a pending word is never stuck.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_reg       <= '0;
         q_valid_reg <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         if (clr) begin
            overrun_reg <= 1'b0;
         end
         if (complete) begin
            if (buf_free) begin
               q_reg       <= shifted;
               q_valid_reg <= 1'b1;
            end else begin
               overrun_reg <= 1'b1;
            end
         end else if (q_valid_reg && q_ready) begin
            q_valid_reg <= 1'b0;
         end
      end
   end

   assign q       = q_reg;
   assign q_valid = q_valid_reg;
   assign overrun = overrun_reg;
   assign bit_cnt = cnt_reg;

endmodule

// File: tb/tb_serial_deser.sv
// tb_serial_deser: directed and randomized checks of serial_deser against a
// frame-level reference model (bit queue per frame, word assembled by
// positional arithmetic, single-slot buffer).
module tb_serial_deser;
   import serial_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         en = 1'b0;
   logic         dir = 1'b0;
   logic         sd = 1'b0;
   logic         clr = 1'b0;
   logic         q_ready = 1'b0;
   logic [W-1:0] q;
   logic         q_valid;
   logic         overrun;
   logic [2:0]   bit_cnt;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic         m_bits[$];
   logic         m_dir = 1'b0;
   logic [W-1:0] m_q = '0;
   logic         m_valid = 1'b0;
   logic         m_ovr = 1'b0;

   serial_deser #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .en(en), .dir(dir), .sd(sd), .clr(clr),
      .q(q), .q_valid(q_valid), .q_ready(q_ready), .overrun(overrun),
      .bit_cnt(bit_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Frame word: bit i of the frame lands at position W-1-i (MSB first)
   // or i (LSB first).
   function automatic logic [W-1:0] assemble(input logic order);
      logic [W-1:0] w = '0;
      for (int i = 0; i < W; i++) begin
         if (order == DIR_LSB_FIRST) w[i] = m_bits[i];
         else                        w[W-1-i] = m_bits[i];
      end
      return w;
   endfunction

   task automatic model_edge();
      logic         done = 1'b0;
      logic [W-1:0] w = '0;
      if (reset) begin
         m_bits.delete();
         m_dir = 1'b0; m_q = '0; m_valid = 1'b0; m_ovr = 1'b0;
         return;
      end
      if (clr) begin
         m_bits.delete();
         m_ovr = 1'b0;
      end else if (en) begin
         if (m_bits.size() == 0) m_dir = dir;
         m_bits.push_back(sd);
         if (m_bits.size() == W) begin
            w = assemble(m_dir);
            done = 1'b1;
            m_bits.delete();
         end
      end
      if (done) begin
         if (!m_valid || q_ready) begin
            m_q = w; m_valid = 1'b1;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (m_valid && q_ready) begin
         m_valid = 1'b0;
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, compare #1 later.
   task automatic cycle(input logic r, input logic c, input logic e,
                        input logic s, input logic d, input logic rdy);
      reset = r; clr = c; en = e; sd = s; dir = d; q_ready = rdy;
      @(posedge clk);
      model_edge();
      #1;
      check("q", 32'(q), 32'(m_q));
      check("q_valid", 32'(q_valid), 32'(m_valid));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("bit_cnt", 32'(bit_cnt), 32'(m_bits.size()));
   endtask

   // Sends one word; ready_last applies only on the final bit, gaps inserts
   // idle cycles between bits, dir flips after bit index toggle_at.
   task automatic send(input logic [W-1:0] word, input logic order,
                       input logic rdy, input logic ready_last,
                       input int gaps, input int toggle_at);
      logic d = order;
      for (int i = 0; i < W; i++) begin
         logic b;
         b = (order == DIR_LSB_FIRST) ? word[i] : word[W-1-i];
         cycle(1'b0, 1'b0, 1'b1, b, d, (i == W-1) ? ready_last : rdy);
         if (i == toggle_at) d = ~d;
         if (i != W-1)
            for (int g = 0; g < gaps; g++) begin
               cycle(1'b0, 1'b0, 1'b0, 1'b0, d, rdy);
               check("gap_no_valid", 32'(q_valid), 32'(m_valid));
            end
      end
   endtask

   initial begin
      // Reset state
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      check("rst_q", 32'(q), 32'h0);
      check("rst_valid", 32'(q_valid), 32'h0);
      check("rst_cnt", 32'(bit_cnt), 32'h0);

      // MSB first
      send(8'h0F, DIR_MSB_FIRST, 1'b1, 1'b1, 0, -1);
      check("msb_q", 32'(q), 32'h0F);
      check("msb_valid", 32'(q_valid), 32'h1);
      check("msb_cnt", 32'(bit_cnt), 32'h0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("msb_valid_one_cycle", 32'(q_valid), 32'h0);

      // LSB first with gaps and a mid-frame dir toggle
      send(8'h0F, DIR_LSB_FIRST, 1'b0, 1'b0, 2, 3);
      check("lsb_q", 32'(q), 32'h0F);
      check("lsb_valid", 32'(q_valid), 32'h1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Overrun
      send(8'hA5, DIR_MSB_FIRST, 1'b0, 1'b0, 0, -1);
      send(8'h3C, DIR_MSB_FIRST, 1'b0, 1'b0, 0, -1);
      check("ovr_q", 32'(q), 32'hA5);
      check("ovr_valid", 32'(q_valid), 32'h1);
      check("ovr_flag", 32'(overrun), 32'h1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("ovr_consumed", 32'(q_valid), 32'h0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ovr_clr", 32'(overrun), 32'h0);

      // Simultaneous complete and consume
      send(8'h11, DIR_MSB_FIRST, 1'b0, 1'b0, 0, -1);
      check("sim_first", 32'(q), 32'h11);
      send(8'h22, DIR_MSB_FIRST, 1'b0, 1'b1, 0, -1);
      check("sim_q", 32'(q), 32'h22);
      check("sim_valid", 32'(q_valid), 32'h1);
      check("sim_ovr", 32'(overrun), 32'h0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Abort with clr on the same edge as en
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      check("abort_cnt", 32'(bit_cnt), 32'h0);
      send(8'hC3, DIR_MSB_FIRST, 1'b1, 1'b1, 0, -1);
      check("abort_q", 32'(q), 32'hC3);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Reset mid-frame with a pending word
      send(8'h55, DIR_MSB_FIRST, 1'b0, 1'b0, 0, -1);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("mrst_q", 32'(q), 32'h0);
      check("mrst_valid", 32'(q_valid), 32'h0);
      check("mrst_cnt", 32'(bit_cnt), 32'h0);
      check("mrst_ovr", 32'(overrun), 32'h0);
      send(8'h81, DIR_MSB_FIRST, 1'b1, 1'b1, 0, -1);
      check("mrst_q2", 32'(q), 32'h81);
      check("mrst_valid2", 32'(q_valid), 32'h1);

      // Randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
               1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
